opcode_encoder: RTL

OPCODE_ENCODER -- requirements
Module: opcode_encoder

---
 rtl/opcode_encoder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/opcode_encoder.sv
// One-hot to binary opcode encoder feeding a 2-entry FIFO with a ready/valid
// handshake on both sides and a saturating count of malformed inputs.
module opcode_encoder (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] DECODED_SIGNAL,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic [2:0] OPCODE,
    output logic       ERROR,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [7:0] ERR_COUNT
);

    localparam int unsigned IN_W  = 8;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [OP_W-1:0]   enc_opcode_c;
    logic              enc_error_c;
    logic              push_c;
    logic              pop_c;

    logic [OP_W-1:0]   mem_opcode [2];
    logic              mem_error  [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic              rd_ptr_d;
    logic [OP_W-1:0]   head_opcode_d;
    logic              head_error_d;

    // Highest set bit wins; zero or multiple bits set flag an error.
    always_comb begin
        enc_opcode_c = '0;
        for (int i = 0; i < int'(IN_W); i++) begin
            if (DECODED_SIGNAL[i]) begin
                enc_opcode_c = OP_W'(i);
            end
        end
        enc_error_c = (DECODED_SIGNAL == '0) ||
                      ((DECODED_SIGNAL & (DECODED_SIGNAL - IN_W'(1))) != '0);
    end

    assign push_c = IN_VALID & IN_READY;
    assign pop_c  = OUT_VALID & OUT_READY;

    // Occupancy state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next state; simultaneous push and pop leaves it unchanged.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (push_c) begin
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push_c && !pop_c) begin
                    state_d = FULL;
                end else if (pop_c && !push_c) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop_c) begin
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Head after this edge: the incoming entry bypasses storage when it
    // lands in the slot the read pointer will point at.
    always_comb begin
        rd_ptr_d = rd_ptr_q ^ pop_c;
        if (push_c && (wr_ptr_q == rd_ptr_d)) begin
            head_opcode_d = enc_opcode_c;
            head_error_d  = enc_error_c;
        end else begin
            head_opcode_d = mem_opcode[rd_ptr_d];
            head_error_d  = mem_error[rd_ptr_d];
        end
    end

    // Storage and pointers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mem_opcode[0] <= '0;
            mem_opcode[1] <= '0;
            mem_error[0]  <= 1'b0;
            mem_error[1]  <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
        end else begin
            if (push_c) begin
                mem_opcode[wr_ptr_q] <= enc_opcode_c;
                mem_error[wr_ptr_q]  <= enc_error_c;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Registered handshake and head outputs, all derived from next state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            IN_READY  <= 1'b0;
            OUT_VALID <= 1'b0;
            OPCODE    <= '0;
            ERROR     <= 1'b0;
        end else begin
            IN_READY  <= (state_d != FULL);
            OUT_VALID <= (state_d != EMPTY);
            OPCODE    <= head_opcode_d;
            ERROR     <= head_error_d;
        end
    end

    // Error count is taken at acceptance and sticks at all ones.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ERR_COUNT <= '0;
        end else if (push_c && enc_error_c && (ERR_COUNT != {CNT_W{1'b1}})) begin
            ERR_COUNT <= ERR_COUNT + CNT_W'(1);
        end
    end

endmodule
